// File: rtl/ir_tx_pkg.sv
// rtl/ir_tx_pkg.sv - shared types and constants for the NEC infrared transmitter
package ir_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK
    } ir_state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;

    // CTRL write bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_IRQ_EN   = 2;

    // NEC durations in time units
    localparam logic [4:0] LEAD_MARK_U  = 5'd16;
    localparam logic [4:0] LEAD_SPACE_U = 5'd8;
    localparam logic [4:0] BIT_MARK_U   = 5'd1;
    localparam logic [4:0] ZERO_SPACE_U = 5'd1;
    localparam logic [4:0] ONE_SPACE_U  = 5'd3;
    localparam logic [4:0] STOP_U       = 5'd1;

    // Number of time units spent in a state; bit_val only matters for BIT_SPACE.
    function automatic logic [4:0] state_units(input ir_state_t st, input logic bit_val);
        case (st)
            ST_LEAD_MARK:  state_units = LEAD_MARK_U;
            ST_LEAD_SPACE: state_units = LEAD_SPACE_U;
            ST_BIT_MARK:   state_units = BIT_MARK_U;
            ST_BIT_SPACE:  state_units = bit_val ? ONE_SPACE_U : ZERO_SPACE_U;
            ST_STOP_MARK:  state_units = STOP_U;
            default:       state_units = 5'd1;
        endcase
    endfunction

    function automatic logic is_mark(input ir_state_t st);
        is_mark = (st == ST_LEAD_MARK) || (st == ST_BIT_MARK) || (st == ST_STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_tx_carrier.sv
// rtl/ir_tx_carrier.sv - carrier period counter with high-half output
// Ports: clk, reset_n (sync, active low), enable (count while high),
//        restart (zero the counter, has priority), carrier_high (first half of period).
module ir_tx_carrier #(
    parameter int CARRIER_DIV = 1316,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic restart,
    output logic carrier_high
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CARRIER_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CARRIER_DIV / 2);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + ONE;
        end
    end

    assign carrier_high = (cnt < HALF);

endmodule

// File: rtl/ir_tx_nec.sv
// rtl/ir_tx_nec.sv - Avalon-MM slave sending one 32-bit NEC IR frame per start
// Ports: clk, reset_n (sync, active low), address/write/writedata/read (bus slave),
//        readdata (registered read mux), ir_out (carrier-modulated LED drive),
//        irq (only when IR_TX_IRQ_EN is defined: done & irq_en, registered).
// Registers: 0 DATA (rw frame word, LSB first); 1 CTRL write {irq_en, clr_done, start},
//            STATUS read {irq_en, done, busy}; 2..3 read as zero.
module ir_tx_nec
    import ir_tx_pkg::*;
#(
    parameter int UNIT_CYCLES = 28125,
    parameter int CARRIER_DIV = 1316,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        ir_out
`ifdef IR_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNIT_ONE  = CNT_W'(1);

    ir_state_t        state;
    logic [31:0]      data_reg;
    logic [31:0]      shift_reg;
    logic [4:0]       bit_idx;
    logic [4:0]       unit_num;
    logic [CNT_W-1:0] unit_cnt;
    logic             done;
    logic             irq_en;

    logic ctrl_wr, start_go, unit_wrap, state_end, in_mark, enter_mark, carrier_high;

    // The read strobe is not needed: readdata tracks the address every cycle.
    logic unused_read;
    assign unused_read = read;

    always_comb begin
        ctrl_wr    = write && (address == ADDR_CTRL);
        start_go   = ctrl_wr && writedata[CTRL_START] && (state == ST_IDLE);
        unit_wrap  = (unit_cnt == UNIT_LAST);
        state_end  = unit_wrap && (unit_num == state_units(state, shift_reg[0]) - 5'd1);
        in_mark    = is_mark(state);
        // Every mark is entered either from IDLE or from the end of a space.
        enter_mark = start_go ||
                     (state_end && ((state == ST_LEAD_SPACE) || (state == ST_BIT_SPACE)));
    end

    ir_tx_carrier #(
        .CARRIER_DIV(CARRIER_DIV),
        .CNT_W      (CNT_W)
    ) u_carrier (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (in_mark),
        .restart     (enter_mark),
        .carrier_high(carrier_high)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            data_reg  <= '0;
            shift_reg <= '0;
            bit_idx   <= '0;
            unit_num  <= '0;
            unit_cnt  <= '0;
            done      <= 1'b0;
            irq_en    <= 1'b0;
            readdata  <= '0;
            ir_out    <= 1'b0;
`ifdef IR_TX_IRQ_EN
            irq       <= 1'b0;
`endif
        end else begin
            ir_out <= in_mark && carrier_high;

            if (write && (address == ADDR_DATA)) begin
                data_reg <= writedata;
            end
            if (ctrl_wr) begin
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            // Completion beats a same-cycle clear.
            if ((state == ST_STOP_MARK) && state_end) begin
                done <= 1'b1;
            end else if (ctrl_wr && writedata[CTRL_CLR_DONE]) begin
                done <= 1'b0;
            end

            case (address)
                ADDR_DATA: readdata <= data_reg;
                ADDR_CTRL: readdata <= {29'd0, irq_en, done, (state != ST_IDLE)};
                default:   readdata <= '0;
            endcase

`ifdef IR_TX_IRQ_EN
            irq <= done && irq_en;
`endif

            if (state == ST_IDLE) begin
                unit_cnt <= '0;
                unit_num <= '0;
                if (start_go) begin
                    state     <= ST_LEAD_MARK;
                    shift_reg <= data_reg;
                    bit_idx   <= '0;
                end
            end else if (state_end) begin
                unit_cnt <= '0;
                unit_num <= '0;
                case (state)
                    ST_LEAD_MARK:  state <= ST_LEAD_SPACE;
                    ST_LEAD_SPACE: state <= ST_BIT_MARK;
                    ST_BIT_MARK:   state <= ST_BIT_SPACE;
                    ST_BIT_SPACE: begin
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= bit_idx + 5'd1;
                        state     <= (bit_idx == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                    end
                    default:       state <= ST_IDLE;
                endcase
            end else begin
                unit_cnt <= unit_wrap ? '0 : unit_cnt + UNIT_ONE;
                if (unit_wrap) begin
                    unit_num <= unit_num + 5'd1;
                end
            end
        end
    end

endmodule
